mem_align_unit: RTL and testbench

- MEM-stage load/store sub-unit for the pipelined MIPS core; the data-side counterpart of the immediate extender.
- Stores: packs byte/half/word data into memory lanes and generates byte enables.
- Loads: extracts the addressed lane from the returned word and zero/sign extends it to 32 bits.
- Runs a request/acknowledge handshake with data memory and stalls the pipeline until the access completes.

---
 rtl/mem_align_unit_if.sv | 54 +++++
 rtl/mem_align_unit.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_align_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_unit_if.sv
// ---------------------------------------------------------------------------
// mem_align_unit_if
//   Bundles the pipeline-side request/response signals and the data-memory
//   bus of the MEM-stage load/store alignment unit.
//
//   Parameter: ADDR_W - byte address width.
//
//   Signals:
//     req_valid/req_we/req_size/req_sign/req_addr/req_wdata  request from MEM stage
//     stall/done/rdata_out/addr_err                          response to pipeline
//     mem_req/mem_we/mem_addr/mem_be/mem_wdata               request to data memory
//     mem_rdata/mem_ack                                      response from data memory
//
//   Modports:
//     master - the environment (pipeline plus data memory)
//     slave  - the alignment unit itself
// ---------------------------------------------------------------------------
interface mem_align_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              stall;
  logic              done;
  logic [31:0]       rdata_out;
  logic              addr_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  stall, done, rdata_out, addr_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output stall, done, rdata_out, addr_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_align_unit.sv
// ---------------------------------------------------------------------------
// mem_align_unit
//   MEM-stage load/store sub-unit. Stores are packed into byte lanes with
//   matching byte enables; loads have the addressed lane extracted from the
//   returned word and zero/sign extended. The unit holds the pipeline with
//   stall while a request/acknowledge transfer with data memory is open.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high reset
//     bus    - mem_align_unit_if.slave (request, response and memory bus)
//
//   Configuration macro: UNALIGNED_TRAP_EN
//     defined   - misaligned half/word requests skip memory and complete
//                 with addr_err = 1 alongside done
//     undefined - addr_err is 0; the offending low address bits are forced
//                 to zero and the access proceeds normally
//
//   Flow: IDLE (accept) -> ACCESS (mem_req held until mem_ack) -> RESP (done)
// ---------------------------------------------------------------------------
module mem_align_unit #(
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             reset,
  mem_align_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Captured request attributes needed after acceptance
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        sign_reg;
  logic [1:0]  off_reg;

  // Registered memory-side and result outputs
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [3:0]        mem_be_reg;
  logic [31:0]       mem_wdata_reg;
  logic [31:0]       rdata_reg;

  logic stall_o;
  logic done_o;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [1:0]  eff_off;
  logic [3:0]  be_new;
  logic [31:0] wdata_lanes;
  logic        trap_req;

  // Effective lane offset: halves drop addr[0], words (and the reserved
  // size) always start at lane 0.
  always_comb begin
    case (bus.req_size)
      2'b00:   eff_off = bus.req_addr[1:0];
      2'b01:   eff_off = {bus.req_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  always_comb begin
    if (!bus.req_we) begin
      be_new = 4'b1111;
    end else begin
      case (bus.req_size)
        2'b00:   be_new = 4'b0001 << eff_off;
        2'b01:   be_new = 4'b0011 << {eff_off[1], 1'b0};
        default: be_new = 4'b1111;
      endcase
    end
  end

  // Lane replication: every lane carries the byte of the store data that
  // would land there, so only mem_be decides which lanes are written.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_lanes[8*gi +: 8] =
          (bus.req_size == 2'b00) ? bus.req_wdata[7:0] :
          (bus.req_size == 2'b01) ? bus.req_wdata[8*(gi%2) +: 8] :
                                    bus.req_wdata[8*gi +: 8];
    end
  endgenerate

`ifdef UNALIGNED_TRAP_EN
  logic misaligned;
  logic err_reg;

  always_comb begin
    case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      default: misaligned = (bus.req_addr[1:0] != 2'b00);
    endcase
  end

  assign trap_req = misaligned;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && bus.req_valid) begin
      err_reg <= misaligned;
    end
  end

  assign bus.addr_err = (state_reg == RESP) && err_reg;
`else
  assign trap_req     = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Load extraction from the returned word
  // ---------------------------------------------------------------------
  logic [31:0] rdata_word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  assign rdata_word = bus.mem_rdata;
  assign byte_lane  = rdata_word[{off_reg, 3'b000} +: 8];
  assign half_lane  = off_reg[1] ? rdata_word[31:16] : rdata_word[15:0];

  always_comb begin
    case (size_reg)
      2'b00:   load_ext = {{24{sign_reg & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{sign_reg & half_lane[15]}}, half_lane};
      default: load_ext = rdata_word;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = trap_req ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_next = RESP;
        end
      end
      // The request still visible in RESP belongs to the completing
      // instruction, so it is never re-accepted here.
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_reg)
      IDLE:    stall_o = bus.req_valid;
      ACCESS:  stall_o = 1'b1;
      RESP:    done_o  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      sign_reg      <= 1'b0;
      off_reg       <= 2'b00;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 4'b0000;
      mem_wdata_reg <= 32'h0;
      rdata_reg     <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            we_reg   <= bus.req_we;
            size_reg <= bus.req_size;
            sign_reg <= bus.req_sign;
            off_reg  <= eff_off;
            // A trapped request never reaches the memory bus.
            if (!trap_req) begin
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= bus.req_we;
              mem_addr_reg  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_be_reg    <= be_new;
              mem_wdata_reg <= wdata_lanes;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_be_reg    <= 4'b0000;
            mem_wdata_reg <= 32'h0;
            if (!we_reg) begin
              rdata_reg <= load_ext;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall     = stall_o;
  assign bus.done      = done_o;
  assign bus.rdata_out = rdata_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_be    = mem_be_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_align_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_align_unit
//   Directed plus randomized bench for mem_align_unit. The bench plays both
//   the MEM stage and the data memory, and predicts byte enables, lane data
//   and load results arithmetically from the address and access size.
//   Honours UNALIGNED_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_align_unit;

  localparam int ADDR_W = 32;
`ifdef UNALIGNED_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_align_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_align_unit #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Comparison helpers
  // ---------------------------------------------------------------------
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model (plain arithmetic on byte counts and offsets)
  // ---------------------------------------------------------------------
  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input int bytes,
                                             input int off, input logic sign);
    longint span;
    longint v;
    span = longint'(1) << (8 * bytes);
    v = (longint'(word) >> (8 * off)) % span;
    if (sign && bytes < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // One full transaction: request in IDLE, memory answers after 'waits'
  // wait cycles, checks every cycle up to and including RESP.
  task automatic do_txn(input string name, input logic we, input logic [1:0] size,
                        input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input bit hold_in_resp);
    int          bytes;
    int          off;
    bit          trap;
    logic [31:0] eff;
    logic [3:0]  be_e;
    logic [31:0] wd_e;

    bytes = size_bytes(size);
    trap  = TRAP && (addr % bytes != 0);
    eff   = addr - (addr % bytes);
    off   = int'(eff % 4);
    be_e  = we ? 4'(((1 << bytes) - 1) << off) : 4'hF;
    for (int i = 0; i < 4; i++) wd_e[8*i +: 8] = wdata[8*(i % bytes) +: 8];

    $display("txn %s we=%0d size=%0d sign=%0d addr=%h wdata=%h rdata=%h waits=%0d trap=%0d",
             name, we, size, sign, addr, wdata, rdata, waits, trap);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
    chk1({name, ".stall_accept"}, bus.stall, 1'b1);
    chk1({name, ".idle_done"}, bus.done, 1'b0);
    chk1({name, ".idle_mem_req"}, bus.mem_req, 1'b0);

    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    #1;
    if (!trap) begin
      for (int c = 0; c <= waits; c++) begin
        chk1 ({name, ".acc_mem_req"}, bus.mem_req, 1'b1);
        chk1 ({name, ".acc_mem_we"}, bus.mem_we, we);
        chk32({name, ".acc_mem_addr"}, bus.mem_addr, {eff[31:2], 2'b00});
        chk32({name, ".acc_mem_be"}, 32'(bus.mem_be), 32'(be_e));
        if (we) chk32({name, ".acc_mem_wdata"}, bus.mem_wdata, wd_e);
        chk1 ({name, ".acc_stall"}, bus.stall, 1'b1);
        chk1 ({name, ".acc_done"}, bus.done, 1'b0);
        bus.mem_ack   = (c == waits);
        bus.mem_rdata = (c == waits) ? rdata : 32'($urandom);
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        #1;
      end
      if (!we) exp_rdata = load_model(rdata, bytes, off, sign);
    end
    // RESP cycle
    chk1 ({name, ".resp_done"}, bus.done, 1'b1);
    chk1 ({name, ".resp_stall"}, bus.stall, 1'b0);
    chk1 ({name, ".resp_mem_req"}, bus.mem_req, 1'b0);
    chk1 ({name, ".resp_addr_err"}, bus.addr_err, trap);
    chk32({name, ".resp_rdata"}, bus.rdata_out, exp_rdata);

    if (hold_in_resp) begin
      // A request visible during RESP must not start a new access.
      bus.req_valid = 1'b1;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      chk1({name, ".resp_ignore_mem_req"}, bus.mem_req, 1'b0);
      chk1({name, ".resp_ignore_stall"}, bus.stall, 1'b0);
      chk1({name, ".resp_ignore_done"}, bus.done, 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sign  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk1 ("reset.stall", bus.stall, 1'b0);
    chk1 ("reset.done", bus.done, 1'b0);
    chk32("reset.rdata_out", bus.rdata_out, 32'h0);
    chk1 ("reset.addr_err", bus.addr_err, 1'b0);
    chk1 ("reset.mem_req", bus.mem_req, 1'b0);
    chk1 ("reset.mem_we", bus.mem_we, 1'b0);
    chk32("reset.mem_addr", bus.mem_addr, 32'h0);
    chk32("reset.mem_be", 32'(bus.mem_be), 32'h0);
    chk32("reset.mem_wdata", bus.mem_wdata, 32'h0);

    // Store byte to the top lane, ack in the first ACCESS cycle
    do_txn("sb_1003", 1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1'b0);
    // Signed and unsigned half loads from the upper half
    do_txn("lh_2002", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 0, 1'b0);
    chk32("plan.lh_value", bus.rdata_out, 32'hFFFF_8001);
    do_txn("lhu_2002", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 0, 1'b0);
    chk32("plan.lhu_value", bus.rdata_out, 32'h0000_8001);
    // Unsigned byte load with three wait states
    do_txn("lbu_0001", 1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h1234_F0CD, 3, 1'b0);
    chk32("plan.lbu_value", bus.rdata_out, 32'h0000_00F0);
    // Store leaves the previous load result in place; RESP ignores req_valid
    do_txn("sh_0102", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 1'b1);

    // Reset while an access is open, then a stray acknowledge
    $display("txn reset_mid_access");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_0040;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk1("rst_mid.mem_req_before", bus.mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1 ("rst_mid.mem_req", bus.mem_req, 1'b0);
    chk1 ("rst_mid.stall", bus.stall, 1'b0);
    chk1 ("rst_mid.done", bus.done, 1'b0);
    chk32("rst_mid.rdata_out", bus.rdata_out, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk1 ("stray_ack.done", bus.done, 1'b0);
    chk1 ("stray_ack.mem_req", bus.mem_req, 1'b0);
    chk32("stray_ack.rdata_out", bus.rdata_out, 32'h0);
    exp_rdata = 32'h0;

    // Misaligned word load: trapped or forced to 0x0004
    do_txn("lw_0006", 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

    // Randomized back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      do_txn($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom), 32'($urandom), 32'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
